// File: rtl/sram_audio_pkg.sv
// Shared state encoding and defaults for the audio SRAM sequencing controller.
package sram_audio_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned DEF_ADDR_W = 18;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_REC_WAIT   = 3'd1,
    ST_REC_WR     = 3'd2,
    ST_PLAY_WAIT  = 3'd3,
    ST_PLAY_RD    = 3'd4,
    ST_PAUSE_REC  = 3'd5,
    ST_PAUSE_PLAY = 3'd6
  } state_e;

  function automatic logic is_rec_state(input state_e s);
    return (s == ST_REC_WAIT) || (s == ST_REC_WR) || (s == ST_PAUSE_REC);
  endfunction

  function automatic logic is_play_state(input state_e s);
    return (s == ST_PLAY_WAIT) || (s == ST_PLAY_RD) || (s == ST_PAUSE_PLAY);
  endfunction

endpackage

// File: rtl/sram_acc_timer.sv
// Loadable down-counter timing one SRAM read or write strobe of ACC_CYCLES cycles.
module sram_acc_timer #(
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic last_o
);

  localparam int unsigned     CNT_W = $clog2(ACC_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(ACC_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/sram_audio_ctrl.sv
// Record/play sequencer for the 256K x 16 audio SRAM: strobe timing, addressing, length tracking.
module sram_audio_ctrl
  import sram_audio_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned MAX_ADDR   = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              pause_req,
  input  logic              stop_req,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic              sram_record,
  output logic              sram_play,
  output logic [2:0]        state_o,
  output logic              full,
  output logic              overrun,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              has_rec_q, has_rec_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;
  logic              val_pend_q, val_pend_d;
  logic              done_pend_q, done_pend_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              pend_stop_q, pend_stop_d;
  logic              pend_pause_q, pend_pause_d;
  logic              rd_q, wr_q, rec_q, play_q;

  logic              tmr_start, tmr_busy, tmr_last, acc_end;
  logic              stop_now, pause_now;

  sram_acc_timer #(
    .ACC_CYCLES(ACC_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(tmr_start),
    .busy_o (tmr_busy),
    .last_o (tmr_last)
  );

  assign acc_end   = tmr_busy && tmr_last;
  assign stop_now  = pend_stop_q || stop_req;
  assign pause_now = pend_pause_q || pause_req;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_addr_d   = end_addr_q;
    has_rec_d    = has_rec_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    full_d       = full_q;
    overrun_d    = overrun_q;
    pend_stop_d  = pend_stop_q;
    pend_pause_d = pend_pause_q;
    tmr_start    = 1'b0;
    val_pend_d   = 1'b0;
    done_pend_d  = 1'b0;
    // Read data captured on the last access cycle is presented one edge later.
    dac_valid_d  = val_pend_q;
    done_d       = done_pend_q;
    dac_data_d   = val_pend_q ? rdata_q : dac_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!stop_req && !pause_req) begin
          if (rec_req) begin
            state_d   = ST_REC_WAIT;
            addr_d    = '0;
            has_rec_d = 1'b0;
            full_d    = 1'b0;
            overrun_d = 1'b0;
          end else if (play_req && has_rec_q) begin
            state_d = ST_PLAY_WAIT;
            addr_d  = '0;
          end
        end
      end

      ST_REC_WAIT: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (pause_req) begin
          state_d = ST_PAUSE_REC;
        end else if (sample_tick) begin
          state_d      = ST_REC_WR;
          wdata_d      = adc_data;
          tmr_start    = 1'b1;
          pend_stop_d  = 1'b0;
          pend_pause_d = 1'b0;
        end
      end

      ST_PLAY_WAIT: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (pause_req) begin
          state_d = ST_PAUSE_PLAY;
        end else if (sample_tick) begin
          state_d      = ST_PLAY_RD;
          tmr_start    = 1'b1;
          pend_stop_d  = 1'b0;
          pend_pause_d = 1'b0;
        end
      end

      ST_PAUSE_REC: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (!pause_req && rec_req) begin
          state_d = ST_REC_WAIT;
        end
      end

      ST_PAUSE_PLAY: begin
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (!pause_req && !rec_req && play_req) begin
          state_d = ST_PLAY_WAIT;
        end
      end

      ST_REC_WR: begin
        if (sample_tick) overrun_d = 1'b1;
        pend_stop_d  = stop_now;
        pend_pause_d = pause_now;
        if (acc_end) begin
          end_addr_d   = addr_q;
          has_rec_d    = 1'b1;
          pend_stop_d  = 1'b0;
          pend_pause_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            if (stop_now)       state_d = ST_IDLE;
            else if (pause_now) state_d = ST_PAUSE_REC;
            else                state_d = ST_REC_WAIT;
          end
        end
      end

      ST_PLAY_RD: begin
        if (sample_tick) overrun_d = 1'b1;
        pend_stop_d  = stop_now;
        pend_pause_d = pause_now;
        if (acc_end) begin
          rdata_d      = sram_rdata;
          val_pend_d   = 1'b1;
          pend_stop_d  = 1'b0;
          pend_pause_d = 1'b0;
          if (addr_q == end_addr_q) begin
            done_pend_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            if (stop_now)       state_d = ST_IDLE;
            else if (pause_now) state_d = ST_PAUSE_PLAY;
            else                state_d = ST_PLAY_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and direction flags are registered from the next state, so each
  // access state owns its strobe for exactly the cycles it is resident.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      end_addr_q   <= '0;
      has_rec_q    <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      dac_data_q   <= '0;
      dac_valid_q  <= 1'b0;
      val_pend_q   <= 1'b0;
      done_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      pend_stop_q  <= 1'b0;
      pend_pause_q <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      rec_q        <= 1'b0;
      play_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_addr_q   <= end_addr_d;
      has_rec_q    <= has_rec_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      dac_data_q   <= dac_data_d;
      dac_valid_q  <= dac_valid_d;
      val_pend_q   <= val_pend_d;
      done_pend_q  <= done_pend_d;
      done_q       <= done_d;
      full_q       <= full_d;
      overrun_q    <= overrun_d;
      pend_stop_q  <= pend_stop_d;
      pend_pause_q <= pend_pause_d;
      rd_q         <= (state_d == ST_PLAY_RD);
      wr_q         <= (state_d == ST_REC_WR);
      rec_q        <= is_rec_state(state_d);
      play_q       <= is_play_state(state_d);
    end
  end

  assign state_o     = state_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;
  assign sram_read   = rd_q;
  assign sram_write  = wr_q;
  assign sram_record = rec_q;
  assign sram_play   = play_q;
  assign dac_data    = dac_data_q;
  assign dac_valid   = dac_valid_q;
  assign done        = done_q;
  assign full        = full_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sram_audio_ctrl.sv
// Directed self-checking bench for sram_audio_ctrl with a small behavioural SRAM.
module tb_sram_audio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_req = 1'b0, play_req = 1'b0, pause_req = 1'b0, stop_req = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] adc_data = '0;
  logic [15:0] sram_rdata;

  logic [15:0] a_dac, a_wdata, b_dac, b_wdata;
  logic [17:0] a_addr, b_addr;
  logic [2:0]  a_state, b_state;
  logic a_valid, a_read, a_write, a_record, a_play, a_full, a_overrun, a_done;
  logic b_valid, b_read, b_write, b_record, b_play, b_full, b_overrun, b_done;

  logic [15:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_audio_ctrl #(.ADDR_W(18), .DATA_W(16), .ACC_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .rec_req(rec_req), .play_req(play_req), .pause_req(pause_req),
    .stop_req(stop_req), .sample_tick(sample_tick), .adc_data(adc_data),
    .dac_data(a_dac), .dac_valid(a_valid), .sram_addr(a_addr), .sram_wdata(a_wdata),
    .sram_rdata(sram_rdata), .sram_read(a_read), .sram_write(a_write),
    .sram_record(a_record), .sram_play(a_play), .state_o(a_state),
    .full(a_full), .overrun(a_overrun), .done(a_done)
  );

  sram_audio_ctrl #(.ADDR_W(18), .DATA_W(16), .ACC_CYCLES(2), .MAX_ADDR(3)) u_dut_b (
    .clk(clk), .rst(rst), .rec_req(rec_req), .play_req(play_req), .pause_req(pause_req),
    .stop_req(stop_req), .sample_tick(sample_tick), .adc_data(adc_data),
    .dac_data(b_dac), .dac_valid(b_valid), .sram_addr(b_addr), .sram_wdata(b_wdata),
    .sram_rdata(sram_rdata), .sram_read(b_read), .sram_write(b_write),
    .sram_record(b_record), .sram_play(b_play), .state_o(b_state),
    .full(b_full), .overrun(b_overrun), .done(b_done)
  );

  always @(posedge clk) begin
    if (a_write) mem[a_addr[3:0]] <= a_wdata;
  end
  assign sram_rdata = mem[a_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_rec();   rec_req = 1'b1;   step(); rec_req = 1'b0;   endtask
  task automatic pulse_play();  play_req = 1'b1;  step(); play_req = 1'b0;  endtask
  task automatic pulse_stop();  stop_req = 1'b1;  step(); stop_req = 1'b0;  endtask
  task automatic pulse_tick();  sample_tick = 1'b1; step(); sample_tick = 1'b0; endtask

  // One recorded sample on instance A: strobe length, address and return state.
  task automatic rec_sample(input logic [15:0] v, input logic [17:0] a, input logic [2:0] end_st);
    int n;
    adc_data = v;
    pulse_tick();
    check("wr_state", a_state, 3'd2);
    check("wr_addr", a_addr, a);
    check("wr_data", a_wdata, v);
    n = 0;
    for (int i = 0; i < 10 && a_state == 3'd2; i++) begin
      if (a_write) n++;
      if (a_read) check("wr_rd_overlap", a_read, 1'b0);
      step();
    end
    check("wr_cycles", n, 2);
    check("wr_end_state", a_state, end_st);
    check("wr_strobe_off", a_write, 1'b0);
  endtask

  initial begin
    int lat, rd, nw;
    logic [15:0] exp_v [3];
    exp_v[0] = 16'h1111;
    exp_v[1] = 16'h2222;
    exp_v[2] = 16'h3333;

    do_reset();
    check("rst_state", a_state, 3'd0);
    check("rst_addr", a_addr, 18'd0);
    check("rst_strobes", {a_read, a_write, a_record, a_play}, 4'b0000);
    check("rst_flags", {a_full, a_overrun, a_done, a_valid}, 4'b0000);
    check("rst_dac", a_dac, 16'h0000);

    // Play with nothing recorded is ignored.
    pulse_play();
    step();
    check("play_norec_state", a_state, 3'd0);
    check("play_norec_strobes", {a_read, a_write, a_play}, 3'b000);

    // Record three samples then stop.
    pulse_rec();
    check("rec_state", a_state, 3'd1);
    check("rec_flag", a_record, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rec_sample(exp_v[k], 18'(k), 3'd1);
      step();
    end
    pulse_stop();
    check("rec_stop_state", a_state, 3'd0);
    check("rec_stop_record", a_record, 1'b0);
    check("rec_overrun", a_overrun, 1'b0);
    check("rec_full", a_full, 1'b0);
    for (int k = 0; k < 3; k++) check("mem_content", mem[k], exp_v[k]);

    // Play back the three samples.
    pulse_play();
    check("play_state", a_state, 3'd3);
    check("play_flag", a_play, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      lat = 0;
      rd = a_read ? 1 : 0;
      while (!a_valid && lat < 8) begin
        step();
        lat++;
        if (a_read) rd++;
      end
      check("play_latency", lat, 3);
      check("play_rd_cycles", rd, 2);
      check("play_dac", a_dac, exp_v[k]);
      check("play_done", a_done, (k == 2) ? 1'b1 : 1'b0);
    end
    step();
    check("play_end_state", a_state, 3'd0);
    check("play_done_pulse", a_done, 1'b0);
    check("play_valid_pulse", a_valid, 1'b0);

    // MAX_ADDR=3 instance: 5 ticks give 4 writes then full.
    do_reset();
    pulse_rec();
    check("max_rec_state", b_state, 3'd1);
    nw = 0;
    for (int k = 0; k < 5; k++) begin
      adc_data = 16'(16'h0A00 + k);
      pulse_tick();
      if (b_write) nw++;
      for (int c = 0; c < 3; c++) begin
        step();
        if (b_write) nw++;
      end
    end
    check("max_write_cycles", nw, 8);
    check("max_full", b_full, 1'b1);
    check("max_state", b_state, 3'd0);
    check("max_overrun", b_overrun, 1'b0);
    check("max_end_addr", b_addr, 18'd3);

    // Pause and overrun during an access, then resume.
    do_reset();
    pulse_rec();
    adc_data = 16'hAAAA;
    pulse_tick();
    check("pz_wr_state", a_state, 3'd2);
    pause_req = 1'b1;
    step();
    pause_req = 1'b0;
    check("pz_still_wr", a_state, 3'd2);
    check("pz_still_strobe", a_write, 1'b1);
    pulse_tick();
    check("pz_state", a_state, 3'd5);
    check("pz_overrun", a_overrun, 1'b1);
    check("pz_addr", a_addr, 18'd1);
    check("pz_strobe", a_write, 1'b0);
    pulse_tick();
    check("pz_tick_ignored", a_state, 3'd5);
    check("pz_no_write", a_write, 1'b0);
    pulse_play();
    check("pz_play_ignored", a_state, 3'd5);
    pulse_rec();
    check("pz_resume_state", a_state, 3'd1);
    check("pz_resume_addr", a_addr, 18'd1);
    rec_sample(16'hBBBB, 18'd1, 3'd1);
    check("pz_mem0", mem[0], 16'hAAAA);
    check("pz_mem1", mem[1], 16'hBBBB);

    // Reset on the first read cycle.
    do_reset();
    pulse_rec();
    rec_sample(16'h5555, 18'd0, 3'd1);
    pulse_stop();
    pulse_play();
    pulse_tick();
    check("rr_rd_state", a_state, 3'd4);
    check("rr_rd_strobe", a_read, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_state", a_state, 3'd0);
    check("rr_strobes", {a_read, a_write, a_record, a_play}, 4'b0000);
    check("rr_addr", a_addr, 18'd0);
    check("rr_flags", {a_full, a_overrun, a_done, a_valid}, 4'b0000);
    check("rr_dac", a_dac, 16'h0000);
    step();
    check("rr_no_late_valid", a_valid, 1'b0);
    pulse_play();
    check("rr_has_rec_cleared", a_state, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
